// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: region counters, request stage, LEAD-deep
// sync/blank delay line and a registered colour-expanding DAC output stage.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_PULSE    = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_PULSE    = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int R_W        = 3,
  parameter int G_W        = 3,
  parameter int B_W        = 2,
  parameter int LEAD       = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pix_ce,
  input  logic [R_W+G_W+B_W-1:0] color_in,
  output logic [10:0]            req_x,
  output logic [10:0]            req_y,
  output logic                   req_valid,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   hsync,
  output logic                   vsync,
  output logic [7:0]             red,
  output logic [7:0]             green,
  output logic [7:0]             blue,
  output logic                   blank_n,
  output logic                   sync_n,
  output logic                   vga_clk
);

  localparam int CW      = R_W + G_W + B_W;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_PULSE + V_BACK;

  // Last count of each region; the region FSMs move on when the counter hits these.
  localparam logic [10:0] H_ACT_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_FRONT_LAST = 11'(H_ACTIVE + H_FRONT - 1);
  localparam logic [10:0] H_PULSE_LAST = 11'(H_ACTIVE + H_FRONT + H_PULSE - 1);
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_ACT_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_FRONT_LAST = 11'(V_ACTIVE + V_FRONT - 1);
  localparam logic [10:0] V_PULSE_LAST = 11'(V_ACTIVE + V_FRONT + V_PULSE - 1);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);

  localparam logic H_POL = (H_SYNC_POL != 0);
  localparam logic V_POL = (V_SYNC_POL != 0);

  typedef enum logic [1:0] {
    REG_ACTIVE,
    REG_FRONT,
    REG_PULSE,
    REG_BACK
  } region_t;

  logic [10:0] h_cnt_reg;
  logic [10:0] v_cnt_reg;
  region_t     h_state_reg;
  region_t     v_state_reg;
  logic        h_wrap;
  logic        v_wrap;

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      h_state_reg <= REG_ACTIVE;
      v_state_reg <= REG_ACTIVE;
    end else if (pix_ce) begin
      h_cnt_reg <= h_wrap ? 11'd0 : h_cnt_reg + 11'd1;
      case (h_state_reg)
        REG_ACTIVE: if (h_cnt_reg == H_ACT_LAST)   h_state_reg <= REG_FRONT;
        REG_FRONT:  if (h_cnt_reg == H_FRONT_LAST) h_state_reg <= REG_PULSE;
        REG_PULSE:  if (h_cnt_reg == H_PULSE_LAST) h_state_reg <= REG_BACK;
        REG_BACK:   if (h_wrap)                    h_state_reg <= REG_ACTIVE;
      endcase
      // The vertical machine only steps on the edge that closes a line.
      if (h_wrap) begin
        v_cnt_reg <= v_wrap ? 11'd0 : v_cnt_reg + 11'd1;
        case (v_state_reg)
          REG_ACTIVE: if (v_cnt_reg == V_ACT_LAST)   v_state_reg <= REG_FRONT;
          REG_FRONT:  if (v_cnt_reg == V_FRONT_LAST) v_state_reg <= REG_PULSE;
          REG_PULSE:  if (v_cnt_reg == V_PULSE_LAST) v_state_reg <= REG_BACK;
          REG_BACK:   if (v_wrap)                    v_state_reg <= REG_ACTIVE;
        endcase
      end
    end
  end

  logic h_vis;
  logic v_vis;

  assign h_vis       = (h_state_reg == REG_ACTIVE);
  assign v_vis       = (v_state_reg == REG_ACTIVE);
  assign req_x       = h_vis ? h_cnt_reg : 11'd0;
  assign req_y       = v_vis ? v_cnt_reg : 11'd0;
  assign req_valid   = h_vis & v_vis;
  assign line_start  = pix_ce & (h_cnt_reg == 11'd0);
  assign frame_start = line_start & (v_cnt_reg == 11'd0);

  // {visible, hpulse, vpulse}; the output register itself is the last of the LEAD stages.
  logic [2:0] req_flags;
  logic [2:0] tap_flags;

  assign req_flags = {req_valid, (h_state_reg == REG_PULSE), (v_state_reg == REG_PULSE)};

  generate
    if (LEAD == 1) begin : g_no_delay
      assign tap_flags = req_flags;
    end else begin : g_delay
      logic [2:0] dly_reg [LEAD-1];

      always_ff @(posedge clock) begin
        if (!reset) begin
          for (int i = 0; i < LEAD - 1; i++) begin
            dly_reg[i] <= 3'b000;
          end
        end else if (pix_ce) begin
          dly_reg[0] <= req_flags;
          for (int i = 1; i < LEAD - 1; i++) begin
            dly_reg[i] <= dly_reg[i-1];
          end
        end
      end

      assign tap_flags = dly_reg[LEAD-2];
    end
  endgenerate

  logic [R_W-1:0] r_field;
  logic [G_W-1:0] g_field;
  logic [B_W-1:0] b_field;
  logic [7:0]     r_exp;
  logic [7:0]     g_exp;
  logic [7:0]     b_exp;

  assign r_field = color_in[CW-1 -: R_W];
  assign g_field = color_in[G_W+B_W-1 -: G_W];
  assign b_field = color_in[B_W-1:0];

  // Each output bit walks the field MSB-first, restarting at the MSB as it runs out.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_expand
      assign r_exp[7-gi] = r_field[R_W-1-(gi % R_W)];
      assign g_exp[7-gi] = g_field[G_W-1-(gi % G_W)];
      assign b_exp[7-gi] = b_field[B_W-1-(gi % B_W)];
    end
  endgenerate

  logic       hsync_reg;
  logic       vsync_reg;
  logic       blank_n_reg;
  logic [7:0] red_reg;
  logic [7:0] green_reg;
  logic [7:0] blue_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      hsync_reg   <= ~H_POL;
      vsync_reg   <= ~V_POL;
      blank_n_reg <= 1'b0;
      red_reg     <= 8'h00;
      green_reg   <= 8'h00;
      blue_reg    <= 8'h00;
    end else if (pix_ce) begin
      hsync_reg   <= tap_flags[1] ? H_POL : ~H_POL;
      vsync_reg   <= tap_flags[0] ? V_POL : ~V_POL;
      blank_n_reg <= tap_flags[2];
      red_reg     <= tap_flags[2] ? r_exp : 8'h00;
      green_reg   <= tap_flags[2] ? g_exp : 8'h00;
      blue_reg    <= tap_flags[2] ? b_exp : 8'h00;
    end
  end

  assign hsync   = hsync_reg;
  assign vsync   = vsync_reg;
  assign blank_n = blank_n_reg;
  assign red     = red_reg;
  assign green   = green_reg;
  assign blue    = blue_reg;
  assign sync_n  = 1'b0;
  assign vga_clk = clock;

endmodule
